ram_port_arbiter: RTL and testbench

- Shares the single-port 32x8 unified RAM between up to NUM_REQ requesters: index 0 program loader, index 1 CPU core, index 2 debug/DMA port.
- Replaces the load_done-selected address/data mux in the top level with a req/gnt/rvalid handshake and round-robin arbitration.
- Sits between the requesters and the RAM; it is the only block that drives the RAM control inputs.

---
 rtl/ram_arb_pkg.sv | 29 ++
 rtl/rr_picker.sv | 55 +++++
 rtl/ram_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the RAM port arbiter: FSM state encoding, default
// RAM geometry and the one-hot helper used to build gnt/rvalid vectors.
// Ports: none (package).
// ----------------------------------------------------------------------------
package ram_arb_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;

   // Upper bound on requesters; requester indices are IDX_W bits wide.
   localparam int MAX_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [MAX_REQ-1:0] vec;
      vec      = {MAX_REQ{1'b0}};
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational winner selection for the RAM port arbiter.
// Default build: round-robin search starting at ptr, wrapping modulo NUM_REQ.
// With ARB_FIXED_PRIORITY_EN defined: plain priority encoder, lowest index
// wins and ptr is ignored.
// Ports:
//   req     - request vector, one bit per requester
//   ptr     - round-robin start index
//   winner  - index of the selected requester (0 when no request)
//   any_req - at least one request bit is set
// ----------------------------------------------------------------------------
module rr_picker
   import ram_arb_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               any_req
);

`ifdef ARB_FIXED_PRIORITY_EN
   // Lowest set index wins; scanning downwards leaves the lowest one last.
   always_comb begin
      winner = {IDX_W{1'b0}};
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            winner = IDX_W'(i);
         end else begin
         end
      end
   end
`else
   // First set request found walking from ptr upwards, modulo NUM_REQ.
   always_comb begin
      logic found;
      winner = {IDX_W{1'b0}};
      found  = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (((int'(ptr) + off) % NUM_REQ) == i)) begin
               winner = IDX_W'(i);
               found  = 1'b1;
            end else begin
            end
         end
      end
   end
`endif

   assign any_req = |req;

endmodule

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port RAM between NUM_REQ requesters (0 loader, 1 CPU,
// 2 debug/DMA) with a req/gnt/rvalid handshake. One access at a time:
// IDLE picks a winner and presents it to the RAM, ACCESS is the single RAM
// cycle (gnt visible), RESP captures read data and pulses rvalid.
// Optional macro ARB_FIXED_PRIORITY_EN: fixed priority (lowest index wins),
// no round-robin pointer. Undefined: round-robin arbitration.
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-high reset
//   req/req_we        - per-requester request and write flag
//   req_addr/req_wdata- flattened per-requester address / write data
//   gnt               - one-hot pulse during the RAM access cycle
//   rvalid/rdata      - one-hot read-complete pulse and read data
//   mem_*             - RAM control/data, driven only by this block
// ----------------------------------------------------------------------------
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic                      mem_write_enable,
   output logic [ADDR_W-1:0]         mem_address,
   output logic [DATA_W-1:0]         mem_data_in,
   input  logic [DATA_W-1:0]         mem_data_out
);

   arb_state_t          state_r;
   arb_state_t          state_nxt_s;
   logic [IDX_W-1:0]    win_r;
   logic [IDX_W-1:0]    win_nxt_s;
   logic                we_r;
   logic                we_nxt_s;
   logic [IDX_W-1:0]    pick_s;
   logic [IDX_W-1:0]    ptr_s;
   logic                any_req_s;
   logic                sel_we_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [DATA_W-1:0]   sel_wdata_s;
   logic [NUM_REQ-1:0]  gnt_nxt_s;
   logic [NUM_REQ-1:0]  rvalid_nxt_s;
   logic [DATA_W-1:0]   rdata_nxt_s;
   logic                mem_we_nxt_s;
   logic [ADDR_W-1:0]   mem_addr_nxt_s;
   logic [DATA_W-1:0]   mem_din_nxt_s;

`ifdef ARB_FIXED_PRIORITY_EN
   assign ptr_s = {IDX_W{1'b0}};
`else
   logic [IDX_W-1:0]    rr_ptr_r;
   logic [IDX_W-1:0]    rr_ptr_nxt_s;
   assign ptr_s = rr_ptr_r;
`endif

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req     (req),
      .ptr     (ptr_s),
      .winner  (pick_s),
      .any_req (any_req_s)
   );

   // Select the winning requester's write flag, address and data.
   always_comb begin
      sel_we_s    = 1'b0;
      sel_addr_s  = {ADDR_W{1'b0}};
      sel_wdata_s = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_s == IDX_W'(i)) begin
            sel_we_s    = req_we[i];
            sel_addr_s  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata_s = req_wdata[i*DATA_W +: DATA_W];
         end else begin
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; writes skip RESP since there is nothing to return.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_nxt_s = ACCESS;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCESS: begin
            if (we_r) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM output logic: next values of the registered outputs and latches.
   // Pulses default to zero; RAM address/data hold their last value.
   always_comb begin
      gnt_nxt_s      = {NUM_REQ{1'b0}};
      rvalid_nxt_s   = {NUM_REQ{1'b0}};
      rdata_nxt_s    = rdata;
      mem_we_nxt_s   = 1'b0;
      mem_addr_nxt_s = mem_address;
      mem_din_nxt_s  = mem_data_in;
      win_nxt_s      = win_r;
      we_nxt_s       = we_r;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_ptr_nxt_s   = rr_ptr_r;
`endif
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               gnt_nxt_s      = NUM_REQ'(onehot(pick_s));
               mem_we_nxt_s   = sel_we_s;
               mem_addr_nxt_s = sel_addr_s;
               mem_din_nxt_s  = sel_wdata_s;
               win_nxt_s      = pick_s;
               we_nxt_s       = sel_we_s;
`ifndef ARB_FIXED_PRIORITY_EN
               if (pick_s == IDX_W'(NUM_REQ - 1)) begin
                  rr_ptr_nxt_s = {IDX_W{1'b0}};
               end else begin
                  rr_ptr_nxt_s = pick_s + IDX_W'(1);
               end
`endif
            end else begin
            end
         end
         ACCESS: begin
            // gnt and write enable fall back to zero through the defaults.
         end
         RESP: begin
            rdata_nxt_s  = mem_data_out;
            rvalid_nxt_s = NUM_REQ'(onehot(win_r));
         end
         default: begin
         end
      endcase
   end

   // Output and access-latch registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gnt              <= {NUM_REQ{1'b0}};
         rvalid           <= {NUM_REQ{1'b0}};
         rdata            <= {DATA_W{1'b0}};
         mem_write_enable <= 1'b0;
         mem_address      <= {ADDR_W{1'b0}};
         mem_data_in      <= {DATA_W{1'b0}};
         win_r            <= {IDX_W{1'b0}};
         we_r             <= 1'b0;
      end else begin
         gnt              <= gnt_nxt_s;
         rvalid           <= rvalid_nxt_s;
         rdata            <= rdata_nxt_s;
         mem_write_enable <= mem_we_nxt_s;
         mem_address      <= mem_addr_nxt_s;
         mem_data_in      <= mem_din_nxt_s;
         win_r            <= win_nxt_s;
         we_r             <= we_nxt_s;
      end
   end

`ifndef ARB_FIXED_PRIORITY_EN
   // Round-robin pointer: one past the most recent winner.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr_r <= {IDX_W{1'b0}};
      end else begin
         rr_ptr_r <= rr_ptr_nxt_s;
      end
   end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_port_arbiter
// Self-checking bench for ram_port_arbiter with an attached 32x8 synchronous
// RAM. A transaction-level reference model (busy window, pointer, memory
// image) predicts every output each cycle. Directed scenarios are followed
// by randomized requester traffic. Honours ARB_FIXED_PRIORITY_EN.
// ----------------------------------------------------------------------------
module tb_ram_port_arbiter;

   localparam int NUM_REQ = 3;
   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 8;

   logic                      clock     = 1'b0;
   logic                      reset     = 1'b1;
   logic [NUM_REQ-1:0]        req       = 3'b000;
   logic [NUM_REQ-1:0]        req_we    = 3'b000;
   logic [NUM_REQ*ADDR_W-1:0] req_addr  = 15'h0000;
   logic [NUM_REQ*DATA_W-1:0] req_wdata = 24'h000000;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]         rdata;
   logic                      mem_write_enable;
   logic [ADDR_W-1:0]         mem_address;
   logic [DATA_W-1:0]         mem_data_in;
   logic [DATA_W-1:0]         mem_data_out = 8'h00;

   int n_assert = 0;
   int n_fail   = 0;

   ram_port_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .req              (req),
      .req_we           (req_we),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .gnt              (gnt),
      .rvalid           (rvalid),
      .rdata            (rdata),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_data_in      (mem_data_in),
      .mem_data_out     (mem_data_out)
   );

   always #5 clock = ~clock;

   // Synchronous single-port RAM: data_out valid one cycle after the address.
   logic [DATA_W-1:0] ram [32] = '{default: 8'h00};
   always @(posedge clock) begin
      if (mem_write_enable) ram[mem_address] <= mem_data_in;
      mem_data_out <= ram[mem_address];
   end

   // ---------------- reference model ----------------
   int               cyc     = 0;
   int               free_at = 0;   // first cycle the arbiter may grant again
   int               rd_at   = -1;  // cycle whose edge delivers rvalid
   int               rd_who  = 0;
   int               ptr     = 0;
   logic [7:0]       rd_data = 8'h00;
   logic [7:0]       refmem [32] = '{default: 8'h00};
   logic [2:0]       exp_gnt    = 3'b000;
   logic [2:0]       exp_rvalid = 3'b000;
   logic [7:0]       exp_rdata  = 8'h00;
   logic             exp_mwe    = 1'b0;
   logic [4:0]       exp_addr   = 5'h00;
   logic [7:0]       exp_din    = 8'h00;
   int               waits [NUM_REQ] = '{default: 0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      ptr        = 0;
      free_at    = 0;
      rd_at      = -1;
      exp_gnt    = 3'b000;
      exp_rvalid = 3'b000;
      exp_rdata  = 8'h00;
      exp_mwe    = 1'b0;
      exp_addr   = 5'h00;
      exp_din    = 8'h00;
   endtask

   // Called just after a rising edge with the inputs the DUT sampled there.
   task automatic model_edge();
      int w;
      int k;
      if (reset) begin
         model_reset();
      end else begin
         exp_gnt    = 3'b000;
         exp_mwe    = 1'b0;
         exp_rvalid = 3'b000;
         if (cyc == rd_at) begin
            exp_rvalid = 3'(1 << rd_who);
            exp_rdata  = rd_data;
         end
         if (cyc >= free_at && req != 3'b000) begin
            w = -1;
            for (int off = 0; off < NUM_REQ; off++) begin
               k = (ptr + off) % NUM_REQ;
               if (w < 0 && req[k]) w = k;
            end
            exp_gnt  = 3'(1 << w);
            exp_mwe  = req_we[w];
            exp_addr = req_addr[w*ADDR_W +: ADDR_W];
            exp_din  = req_wdata[w*DATA_W +: DATA_W];
            if (req_we[w]) begin
               refmem[exp_addr] = exp_din;
               free_at = cyc + 2;
            end else begin
               rd_at   = cyc + 2;
               rd_who  = w;
               rd_data = refmem[exp_addr];
               free_at = cyc + 3;
            end
`ifndef ARB_FIXED_PRIORITY_EN
            ptr = (w + 1) % NUM_REQ;
`endif
         end
      end
      cyc++;
   endtask

   task automatic compare_all();
      check("gnt",      32'(gnt),              32'(exp_gnt));
      check("rvalid",   32'(rvalid),           32'(exp_rvalid));
      check("rdata",    32'(rdata),            32'(exp_rdata));
      check("mem_we",   32'(mem_write_enable), 32'(exp_mwe));
      check("mem_addr", 32'(mem_address),      32'(exp_addr));
      check("mem_din",  32'(mem_data_in),      32'(exp_din));
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic cycle();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      compare_all();
   endtask

   task automatic set_req(input int i, input logic on, input logic we,
                          input logic [4:0] a, input logic [7:0] d);
      req[i]                       = on;
      req_we[i]                    = we;
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_wdata[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic new_txn(input int i);
      set_req(i, 1'b1, 1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)),
              8'($urandom_range(255, 0)));
   endtask

   function automatic int oh2idx(input logic [2:0] v);
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
      return 7;
   endfunction

   int         order [4];
   int         exp_order [4];
   int         n_gr;
   logic       saw_g2;

   initial begin
      // ---- reset state ----
      repeat (2) @(posedge clock);
      @(negedge clock);
      model_reset();
      compare_all();
      reset = 1'b0;

      // ---- single write then read-back ----
      set_req(0, 1'b1, 1'b1, 5'h03, 8'hA5);
      cycle();
      check("wr_gnt",  32'(gnt), 32'(3'b001));
      check("wr_we",   32'(mem_write_enable), 32'(1'b1));
      check("wr_addr", 32'(mem_address), 32'(5'h03));
      req[0] = 1'b0;
      cycle();
      cycle();
      set_req(1, 1'b1, 1'b0, 5'h03, 8'h00);
      cycle();
      check("rd_gnt", 32'(gnt), 32'(3'b010));
      req[1] = 1'b0;
      cycle();
      cycle();
      check("rd_rvalid", 32'(rvalid), 32'(3'b010));
      check("rd_data",   32'(rdata),  32'(8'hA5));
      cycle();

      // ---- contention from reset, each re-asserted after its grant ----
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, 5'(8 + i), 8'(16 * i + 1));
`ifdef ARB_FIXED_PRIORITY_EN
      exp_order = '{0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 0};
`endif
      order = '{7, 7, 7, 7};
      n_gr  = 0;
      for (int c = 0; c < 20 && n_gr < 4; c++) begin
         cycle();
         if (gnt != 3'b000) begin
            order[n_gr] = oh2idx(gnt);
            n_gr++;
         end
         for (int i = 0; i < NUM_REQ; i++)
            if (exp_gnt[i]) set_req(i, 1'b1, 1'b1, 5'(8 + i), 8'($urandom_range(255, 0)));
      end
      for (int k = 0; k < 4; k++) check("contention_order", 32'(order[k]), 32'(exp_order[k]));
      req = 3'b000;
      repeat (3) cycle();

      // ---- reset in the RESP cycle of a read ----
      set_req(1, 1'b1, 1'b0, 5'h07, 8'h00);
      cycle();
      req[1] = 1'b0;
      cycle();
      reset = 1'b1;
      #1;
      check("rst_gnt",    32'(gnt),              32'(3'b000));
      check("rst_rvalid", 32'(rvalid),           32'(3'b000));
      check("rst_rdata",  32'(rdata),            32'(8'h00));
      check("rst_we",     32'(mem_write_enable), 32'(1'b0));
      check("rst_addr",   32'(mem_address),      32'(5'h00));
      check("rst_din",    32'(mem_data_in),      32'(8'h00));
      model_reset();
      cycle();
      reset = 1'b0;
      set_req(0, 1'b1, 1'b1, 5'h02, 8'h5A);
      set_req(2, 1'b1, 1'b1, 5'h04, 8'h3C);
      cycle();
      check("post_rst_gnt0", 32'(gnt), 32'(3'b001));
      req[0] = 1'b0;
      cycle();
      cycle();
      check("post_rst_gnt2", 32'(gnt), 32'(3'b100));
      req[2] = 1'b0;
      repeat (2) cycle();

      // ---- request withdrawn while another access is in flight ----
      set_req(1, 1'b1, 1'b0, 5'h03, 8'h00);
      cycle();
      req[1] = 1'b0;
      set_req(2, 1'b1, 1'b0, 5'h05, 8'h00);
      saw_g2 = gnt[2];
      cycle();
      saw_g2 |= gnt[2];
      req[2] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         saw_g2 |= gnt[2];
      end
      check("withdrawn_no_gnt2", 32'(saw_g2), 32'(1'b0));

      // ---- randomized traffic ----
      for (int c = 0; c < 3000; c++) begin
         cycle();
`ifndef ARB_FIXED_PRIORITY_EN
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req[i]) begin
               waits[i] = 0;
            end else if (gnt != 3'b000) begin
               if (gnt[i]) begin
                  check("starvation_bound", 32'(waits[i] < NUM_REQ), 32'(1'b1));
                  waits[i] = 0;
               end else begin
                  waits[i]++;
               end
            end
         end
`endif
         for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_gnt[i]) begin
               if ($urandom_range(1, 0) == 1) new_txn(i);
               else req[i] = 1'b0;
            end else if (req[i]) begin
               if ($urandom_range(15, 0) == 0) req[i] = 1'b0;
            end else if ($urandom_range(2, 0) == 0) begin
               new_txn(i);
            end
         end
      end
      req = 3'b000;
      repeat (4) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
